load_store_unit: RTL

Data-side load/store unit between the RISC-V single-cycle core and data memory. It takes the core's load or store request (the same cycle `isLoad`/`isStore` are decoded), stalls the core, and runs a valid/ready transaction on the memory port. For stores it lane-aligns the write data and generates byte strobes. For loads it selects, sign- or zero-extends and returns the load data in the retire cycle. Misaligned addresses, illegal funct3 values and memory timeouts are reported on a single-cycle `fault` pulse.

---
 rtl/load_store_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Purpose : data-side load/store unit; checks, formats and runs one core memory access over a valid/ready port.
// Latency : request accepted in IDLE, mem_req from the next cycle, result/retire one cycle after mem_ready.
// Backpress: core is stalled while a request is pending; mem_req is held with stable mem_* until mem_ready or timeout.
//
// Ports:
//   clk, reset (async active-low)      - clock and reset
//   req_valid/store/funct3/addr/wdata  - core request, held stable while stall is 1
//   stall, load_valid, load_data, fault- core-side status and load result
//   mem_req/we/addr/wdata/wstrb        - memory request (registered, stable during BUSY)
//   mem_ready, mem_rdata               - memory acceptance and read data
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   ldata_q, ldata_d;

    // ------------------------------------------------------------------
    // Request checking
    // ------------------------------------------------------------------
    logic req_illegal;
    logic req_misalign;

    always_comb begin
        req_illegal = 1'b0;
        if (req_store) begin
            req_illegal = (req_funct3 >= 3'd3);
        end else begin
            req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
    end

    // funct3[1:0] encodes access size for every legal opcode (0 byte, 1 half, 2 word).
    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = (req_addr[1:0] != 2'b00);
            default: req_misalign = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store formatting: replicate data across lanes, strobe selects lane(s)
    // ------------------------------------------------------------------
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'd0: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load formatting from the latched lane offset and funct3
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        ld_fmt = mem_rdata;
        case (f3_q)
            3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_fmt = {24'b0, ld_byte};
            3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_fmt = {16'b0, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        f3_d    = f3_q;
        ldata_d = ldata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal || req_misalign) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_BUSY;
                        addr_d  = {req_addr[31:2], 2'b00};
                        we_d    = req_store;
                        wdata_d = st_wdata;
                        wstrb_d = req_store ? st_wstrb : 4'b0000;
                        off_d   = req_addr[1:0];
                        f3_d    = req_funct3;
                        cnt_d   = '0;
                    end
                end
            end
            S_BUSY: begin
                // A ready in the expiry cycle still completes the access.
                if (mem_ready) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        ldata_d = ld_fmt;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The core still presents the retiring instruction in DONE, so req_valid is ignored.
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            ldata_q <= ldata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // stall looks at req_valid combinationally, so it is gated by reset to stay 0 during reset.
    assign stall      = reset && (((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY));
    assign mem_req    = (state_q == S_BUSY);
    assign load_valid = (state_q == S_DONE) && !we_q;
    assign fault      = (state_q == S_FAULT);
    assign load_data  = ldata_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

endmodule
